// File: rtl/corePckg.sv
// Shared core types: register width and the memory-op bundle
// handed from execute to the load/store RAM port.
package corePckg;

    localparam int cXLEN = 32;

    typedef struct packed {
        logic [cXLEN-1:0] addr;
        logic             read;
        logic             write;
        logic [2:0]       opType;
        logic [cXLEN-1:0] data;
        logic [4:0]       rdAddr;
    } tMemOp;

endpackage

// File: rtl/mem_op_issue_if.sv
// Load/store request handshake from execute into mem_op_issue.
// master = execute side, slave = issue unit.
interface mem_op_issue_if;
    import corePckg::*;

    logic             iValid;
    logic             oReady;
    logic             iIsLoad;
    logic             iIsStore;
    logic [2:0]       iFunct3;
    logic [cXLEN-1:0] iBase;
    logic [cXLEN-1:0] iImm;
    logic [cXLEN-1:0] iStoreData;
    logic [4:0]       iRdAddr;

    modport master (
        output iValid, iIsLoad, iIsStore, iFunct3,
        output iBase, iImm, iStoreData, iRdAddr,
        input  oReady
    );

    modport slave (
        input  iValid, iIsLoad, iIsStore, iFunct3,
        input  iBase, iImm, iStoreData, iRdAddr,
        output oReady
    );

endinterface

// File: rtl/mem_op_issue.sv
// Load/store issue queue: EA + alignment check, FIFO, one tMemOp/cycle.
// MEMOPISSUE_HAZARD_EN builds the load-use hazard tracker.
module mem_op_issue
    import corePckg::*;
#(
    parameter int cDepth   = 4,
    parameter int cLoadLat = 2
)(
    input  logic                   iClk,
    input  logic                   iRst,
    mem_op_issue_if.slave          req,
    input  logic                   iHold,
    input  logic                   iFlush,
    input  logic [4:0]             iChkAddrA,
    input  logic [4:0]             iChkAddrB,
    output logic                   oLoadHazard,
    output logic                   oMisalign,
    output tMemOp                  oMemOp,
    output logic [$clog2(cDepth):0] oCount
);

    localparam int cPtrW = $clog2(cDepth);

    tMemOp            fifo [cDepth];
    logic [cPtrW-1:0] wrPtr;
    logic [cPtrW-1:0] rdPtr;
    logic [cPtrW:0]   count;

    logic [cXLEN-1:0] addr;
    logic             misal;
    logic             accept;
    logic             push;
    logic             pop;
    tMemOp            entry;
    tMemOp            issueOp;

    assign req.oReady = (count < (cPtrW+1)'(cDepth));
    assign oCount     = count;

    always_comb begin
        addr  = req.iBase + req.iImm;
        misal = 1'b0;
        unique case (1'b1)
            (req.iFunct3[1:0] == 2'b10): misal = (addr[1:0] != 2'b00);
            (req.iFunct3[1:0] == 2'b01): misal = addr[0];
            default:                     misal = 1'b0;
        endcase
        accept = req.iValid & req.oReady;
        push   = accept & ~misal & ~iFlush;
        pop    = (count != '0) & ~iHold & ~iFlush;

        entry        = '0;
        entry.addr   = addr;
        entry.read   = req.iIsLoad;
        entry.write  = req.iIsStore;
        entry.opType = req.iFunct3;
        entry.data   = req.iStoreData;
        entry.rdAddr = req.iIsLoad ? req.iRdAddr : 5'd0;

        // Non-issue cycles still carry the head fields; only read/write matter.
        issueOp       = fifo[rdPtr];
        issueOp.read  = pop & fifo[rdPtr].read;
        issueOp.write = pop & fifo[rdPtr].write;
    end

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            for (int i = 0; i < cDepth; i++) begin
                fifo[i] <= '0;
            end
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            oMemOp    <= '0;
            oMisalign <= 1'b0;
        end else begin
            oMisalign <= accept & misal & ~iFlush;
            oMemOp    <= issueOp;
            if (push) begin
                fifo[wrPtr] <= entry;
            end
            if (iFlush) begin
                wrPtr <= '0;
                rdPtr <= '0;
                count <= '0;
            end else begin
                if (push) wrPtr <= wrPtr + 1'b1;
                if (pop)  rdPtr <= rdPtr + 1'b1;
                unique case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

`ifdef MEMOPISSUE_HAZARD_EN
    logic [cLoadLat-1:0] trkVld;
    logic [4:0]          trkRd [cLoadLat];

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            trkVld <= '0;
            for (int i = 0; i < cLoadLat; i++) begin
                trkRd[i] <= '0;
            end
        end else begin
            for (int i = cLoadLat - 1; i > 0; i--) begin
                trkVld[i] <= trkVld[i-1];
                trkRd[i]  <= trkRd[i-1];
            end
            trkVld[0] <= issueOp.read;
            trkRd[0]  <= issueOp.rdAddr;
        end
    end

    function automatic logic hit(input logic [4:0] rd);
        return (iChkAddrA != 5'd0 && iChkAddrA == rd) ||
               (iChkAddrB != 5'd0 && iChkAddrB == rd);
    endfunction

    always_comb begin
        logic [cPtrW-1:0] offs;
        offs        = '0;
        oLoadHazard = 1'b0;
        // Slot i is live when its distance from the head is below count.
        for (int i = 0; i < cDepth; i++) begin
            offs = cPtrW'(i) - rdPtr;
            if (({1'b0, offs} < count) && fifo[i].read &&
                hit(fifo[i].rdAddr)) begin
                oLoadHazard = 1'b1;
            end
        end
        for (int i = 0; i < cLoadLat; i++) begin
            if (trkVld[i] && hit(trkRd[i])) begin
                oLoadHazard = 1'b1;
            end
        end
    end
`else
    logic unusedChk;
    assign unusedChk   = ^{iChkAddrA, iChkAddrB};
    assign oLoadHazard = 1'b0;
`endif

    aKind: assert property (@(posedge iClk) disable iff (!iRst)
        req.iValid |-> (req.iIsLoad ^ req.iIsStore));

    aCount: assert property (@(posedge iClk) disable iff (!iRst)
        count <= (cPtrW+1)'(cDepth));

endmodule
